// File: rtl/demux1to4_pkg.sv
// Shared types and sizes for the 1-to-4 registered distributor.
// Optional delivered-word counters are enabled with DEMUX_CNT_EN.
package demux1to4_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NCH    = 4;
  localparam int unsigned SEL_W  = 2;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

endpackage

// File: rtl/demux_slot.sv
// One output channel: one-entry data register with EMPTY/FULL state.
// DEMUX_CNT_EN adds an 8-bit wrapping delivered-word counter.
module demux_slot
  import demux1to4_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_i,
  input  data_t data_i,
  input  logic  ready_i,
`ifdef DEMUX_CNT_EN
  output logic [DATA_W-1:0] cnt_o,
`endif
  output data_t data_o,
  output logic  valid_o
);

  chan_state_e state_q, state_d;
  data_t       data_q, data_d;
  logic        deliver;

  assign deliver = (state_q == FULL) && ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A load wins over a drain: the old word leaves, the new one stays resident.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      EMPTY: begin
        if (load_i) begin
          state_d = FULL;
          data_d  = data_i;
        end
      end
      FULL: begin
        if (load_i) begin
          data_d = data_i;
        end else if (ready_i) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign data_o  = data_q;
  assign valid_o = (state_q == FULL);

`ifdef DEMUX_CNT_EN
  logic [DATA_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (deliver) begin
      cnt_d = cnt_q + DATA_W'(1);
    end
  end

  assign cnt_o = cnt_q;
`else
  logic unused_deliver;
  assign unused_deliver = deliver;
`endif

endmodule

// File: rtl/demux1to4.sv
// Registered 1-to-4 distributor: steers each accepted word to one channel slot.
// DEMUX_CNT_EN exposes per-channel delivered-word counters cnt1..cnt4.
module demux1to4
  import demux1to4_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out1,
  output logic [DATA_W-1:0]   out2,
  output logic [DATA_W-1:0]   out3,
  output logic [DATA_W-1:0]   out4,
`ifdef DEMUX_CNT_EN
  output logic [DATA_W-1:0]   cnt1,
  output logic [DATA_W-1:0]   cnt2,
  output logic [DATA_W-1:0]   cnt3,
  output logic [DATA_W-1:0]   cnt4,
`endif
  output logic [NCH-1:0]      out_valid,
  input  logic [NCH-1:0]      out_ready
);

  data_t          chan_data [NCH];
  logic [NCH-1:0] load;
  logic           accept;

  // Addressed channel can take a word if empty or being drained this cycle.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
  assign accept   = in_valid && in_ready;

`ifdef DEMUX_CNT_EN
  data_t chan_cnt [NCH];
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    assign load[k] = accept && (in_sel == SEL_W'(k));

    demux_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[k]),
      .data_i  (in_data),
      .ready_i (out_ready[k]),
`ifdef DEMUX_CNT_EN
      .cnt_o   (chan_cnt[k]),
`endif
      .data_o  (chan_data[k]),
      .valid_o (out_valid[k])
    );
  end

  assign out1 = chan_data[0];
  assign out2 = chan_data[1];
  assign out3 = chan_data[2];
  assign out4 = chan_data[3];

`ifdef DEMUX_CNT_EN
  assign cnt1 = chan_cnt[0];
  assign cnt2 = chan_cnt[1];
  assign cnt3 = chan_cnt[2];
  assign cnt4 = chan_cnt[3];
`endif

endmodule

// File: tb/tb_demux1to4.sv
// Self-checking bench for demux1to4 with a queue-free per-channel reference model.
// Counter checks are compiled in when DEMUX_CNT_EN is defined.
module tb_demux1to4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out1, out2, out3, out4;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
`ifdef DEMUX_CNT_EN
  logic [7:0] cnt1, cnt2, cnt3, cnt4;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what each channel holds and how many words it has delivered.
  logic [3:0] m_valid;
  logic [7:0] m_data [4];
  logic [7:0] m_cnt  [4];
  logic [7:0] obs    [4];

  assign obs[0] = out1;
  assign obs[1] = out2;
  assign obs[2] = out3;
  assign obs[3] = out4;

  always #5 clk = ~clk;

  demux1to4 dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
`ifdef DEMUX_CNT_EN
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3),
    .cnt4      (cnt4),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic model_clear();
    m_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      m_data[k] = 8'h00;
      m_cnt[k]  = 8'h00;
    end
  endtask

  // Advance one clock edge, applying the channel rules to the model.
  task automatic cycle();
    logic acc;
    acc = in_valid && (!m_valid[in_sel] || out_ready[in_sel]);
    for (int k = 0; k < 4; k++) begin
      if (m_valid[k] && out_ready[k]) begin
        m_cnt[k]   = m_cnt[k] + 8'd1;
        m_valid[k] = 1'b0;
      end
    end
    if (acc) begin
      m_valid[in_sel] = 1'b1;
      m_data[in_sel]  = in_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'b0000;
    model_clear();
    #3;
    n_checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1 || {out1, out2, out3, out4} !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_init: valid=%b ready=%b outs=%h%h%h%h want 0000/1/0", out_valid, in_ready, out1, out2, out3, out4);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    // Fill all four channels, then reset asynchronously mid-cycle.
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_sel = 2'(k); in_data = 8'h10 + 8'(k);
      cycle();
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 4'b1111) begin
      n_errors++;
      $display("FAIL reset_fill: valid=%b want 1111", out_valid);
    end
    #2 rst = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1 || {out1, out2, out3, out4} !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_async: valid=%b ready=%b outs=%h%h%h%h want 0000/1/0", out_valid, in_ready, out1, out2, out3, out4);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_steer();
    out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL steer_ready: in_ready=%b want 1", in_ready);
    end
    cycle();
    in_valid = 1'b0;
    n_checks++;
    if (out3 !== 8'hA5 || out_valid !== 4'b0100 || out1 !== 8'h00 || out2 !== 8'h00 || out4 !== 8'h00) begin
      n_errors++;
      $display("FAIL steer_out3: out3=%h valid=%b o1=%h o2=%h o4=%h want A5/0100/00", out3, out_valid, out1, out2, out4);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h11;
    cycle();
    in_data = 8'h22;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_stall: in_ready=%b want 0", in_ready);
    end
    cycle();
    n_checks++;
    if (out1 !== 8'h11 || out_valid[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_hold: out1=%h v0=%b want 11/1", out1, out_valid[0]);
    end
    out_ready = 4'b0001;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_release: in_ready=%b want 1", in_ready);
    end
    cycle();
    in_valid = 1'b0;
    n_checks++;
    if (out1 !== 8'h22 || out_valid[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_replace: out1=%h v0=%b want 22/1", out1, out_valid[0]);
    end
    cycle();
    n_checks++;
    if (out1 !== 8'h22 || out_valid[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_drain: out1=%h v0=%b want 22/0", out1, out_valid[0]);
    end
  endtask

  task automatic test_streaming();
    out_ready = 4'b1000; in_valid = 1'b1; in_sel = 2'd3;
    for (int w = 1; w <= 4; w++) begin
      in_data = 8'(w);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL stream_ready%0d: in_ready=%b want 1", w, in_ready);
      end
      cycle();
      n_checks++;
      if (out4 !== 8'(w) || out_valid[3] !== 1'b1) begin
        n_errors++;
        $display("FAIL stream_word%0d: out4=%h v3=%b want %h/1", w, out4, out_valid[3], 8'(w));
      end
    end
    in_valid = 1'b0;
    cycle();
    n_checks++;
    if (out_valid[3] !== 1'b0) begin
      n_errors++;
      $display("FAIL stream_end: v3=%b want 0", out_valid[3]);
    end
  endtask

  task automatic test_concurrency();
    in_valid = 1'b0; out_ready = 4'b1111;
    cycle();
    out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h33;
    cycle();
    n_checks++;
    if (out_valid !== 4'b0010) begin
      n_errors++;
      $display("FAIL conc_setup: valid=%b want 0010", out_valid);
    end
    out_ready = 4'b0010; in_sel = 2'd3; in_data = 8'h5C;
    cycle();
    in_valid = 1'b0; out_ready = 4'b0000;
    n_checks++;
    if (out_valid !== 4'b1000 || out4 !== 8'h5C || out2 !== 8'h33) begin
      n_errors++;
      $display("FAIL conc_swap: valid=%b out4=%h out2=%h want 1000/5C/33", out_valid, out4, out2);
    end
  endtask

  task automatic test_random();
    logic pending;
    pending = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pending) begin
        in_valid = ($urandom_range(3) != 0);
        in_sel   = 2'($urandom_range(3));
        in_data  = 8'($urandom);
      end
      out_ready = 4'($urandom);
      #1;
      n_checks++;
      if (in_ready !== (!m_valid[in_sel] || out_ready[in_sel])) begin
        n_errors++;
        $display("FAIL rand_ready@%0d: in_ready=%b want %b", i, in_ready, !m_valid[in_sel] || out_ready[in_sel]);
      end
      pending = in_valid && !in_ready;
      cycle();
      n_checks++;
      if (out_valid !== m_valid) begin
        n_errors++;
        $display("FAIL rand_valid@%0d: valid=%b want %b", i, out_valid, m_valid);
      end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs[k] !== m_data[k]) begin
          n_errors++;
          $display("FAIL rand_data@%0d ch%0d: got %h want %h", i, k + 1, obs[k], m_data[k]);
        end
      end
`ifdef DEMUX_CNT_EN
      n_checks++;
      if ({cnt1, cnt2, cnt3, cnt4} !== {m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]}) begin
        n_errors++;
        $display("FAIL rand_cnt@%0d: got %h %h %h %h want %h %h %h %h", i, cnt1, cnt2, cnt3, cnt4, m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
      end
`endif
    end
    in_valid = 1'b0; out_ready = 4'b0000;
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_counter();
    @(negedge clk); rst = 1'b1; model_clear();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_sel = 2'd0; out_ready = 4'b0001;
    for (int i = 0; i < 257; i++) begin
      in_data = 8'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    out_ready = 4'b0000;
    n_checks++;
    if (cnt1 !== 8'h01 || cnt2 !== 8'h00 || cnt3 !== 8'h00 || cnt4 !== 8'h00) begin
      n_errors++;
      $display("FAIL cnt_wrap: cnt=%h %h %h %h want 01 00 00 00", cnt1, cnt2, cnt3, cnt4);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_steer();
    test_backpressure();
    test_streaming();
    test_concurrency();
    test_random();
`ifdef DEMUX_CNT_EN
    test_counter();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux1to4.md
# demux1to4

Registered 1-to-4 distributor: the inverse of the datapath's 4-to-1 selector. Accepts one 8-bit word per cycle on a valid/ready input port, steers it by a 2-bit select to one of four output channels, and holds it in a one-entry per-channel register until that consumer takes it. Sits between a single result producer and four downstream consumers (register-file write ports, output latches).

## Interface
- No parameters; data width fixed at 8, channel count fixed at 4.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  8  word to distribute
- in_sel  input  2  destination channel: 0→out1, 1→out2, 2→out3, 3→out4
- in_valid  input  1  in_data/in_sel are valid
- in_ready  output  1  word accepted this cycle when in_valid && in_ready
- out1..out4  output  8 each  channel data registers
- out_valid  output  4  bit k = channel k+1 holds a word
- out_ready  input  4  bit k = consumer k+1 takes the word this cycle
- cnt1..cnt4  output  8 each  delivered-word counters (only with DEMUX_CNT_EN)

## Operation
- Each channel is a two-state machine: EMPTY (out_valid[k]=0), FULL (out_valid[k]=1).
- Input accept: in_ready = !out_valid[in_sel] || out_ready[in_sel]. Combinational path out_ready→in_ready is intentional; no path from in_valid to in_ready.
- Load: on accept, channel in_sel captures in_data and goes/stays FULL. No other channel changes data.
- Drain: FULL && out_ready[k] && no load into k this cycle → EMPTY; data register holds its last value.
- Simultaneous drain and load on the same channel: old word delivered, new word captured, channel stays FULL (full throughput, one word per cycle per channel).
- Drains on channels other than in_sel are independent and may occur in the same cycle as an accept.
- in_sel is ignored when in_valid=0; in_ready still reflects the currently addressed channel.
- out_ready on an EMPTY channel has no effect.
- Producer must hold in_data/in_sel/in_valid stable until accepted; block does not check.

## Timing
- Latency: word accepted at edge N appears on outK with out_valid set after edge N (visible cycle N+1).
- Reset (async assert, sync-safe release): out_valid=4'b0000, out1..out4=8'h00, cnt1..cnt4=8'h00; in_ready therefore 1 during and after reset.
- Reset mid-transfer: held words are discarded, no delivery counted.
- Throughput: one accept per cycle total; sustained 1/cycle to one channel only if its consumer holds out_ready high.

## Configuration
- DEMUX_CNT_EN defined: ports cnt1..cnt4 exist; cntK increments by 1 on each cycle where out_valid[K-1] && out_ready[K-1]; 8-bit, wraps 8'hFF→8'h00; reset 0.
- DEMUX_CNT_EN undefined: cnt ports and counter logic absent; all other behaviour identical.

## Structure
- Shared package: DATA_W=8, NCH=4, sel typedef (2-bit), channel state enum {EMPTY, FULL}.
- Sub-module demux_slot: one channel (data register, state, load/drain logic, optional counter), instantiated four times; top holds only select decode and in_ready mux.

## Test plan
- Reset: assert rst mid-run with channels FULL → out_valid=0000, out1..out4=00, in_ready=1 immediately (asynchronous).
- Basic steer: in_data=8'hA5, in_sel=2, out_ready=0000 → after one edge out3=A5, out_valid=0100; others unchanged.
- Backpressure: channel 1 FULL, out_ready[0]=0, in_sel=0, in_valid=1 → in_ready=0, out1 retains value; raise out_ready[0] → in_ready=1, next word captured, out_valid[0] stays 1.
- Streaming: in_sel=3, out_ready=1000, words 01,02,03,04 back-to-back → out4 shows each one cycle after accept, no bubbles, in_ready constant 1.
- Concurrency: channel 2 draining while word 8'h5C accepted for channel 4 → out_valid goes 0010→1000 in one edge.
- DEMUX_CNT_EN: 257 deliveries on channel 1 → cnt1=8'h01; cnt2..cnt4=0; build without macro compiles with no cnt ports.
